hamming15_inject_sched: RTL
===========================

// Module: hamming15_inject_sched
// PURPOSE
//  Controller/scheduler around a Hamming(15,11) encoder with single-bit error injection.
//  Accepts 11-bit data words over valid/ready and drives them through the encoder.
//  Decides, per word, which codeword bit (1..15, or none) is flipped.
//  Emits the 15-bit codeword through a registered valid/ready output.
//  Sits between the traffic source and the decoder under test in the ECC test harness.
// PARAMETERS
//  CNT_W  16  width of the accepted-word and injected-error counters (saturating)
// PORTS
//  clock        in   1   single clock; all state updates on posedge
//  reset        in   1   synchronous, active-high reset
//  start        in   1   pulse: sample cfg_*, enter RUN (ignored unless IDLE)
//  stop         in   1   pulse: stop accepting input, enter DRAIN (ignored in IDLE)
//  cfg_mode     in   2   00 off, 01 fixed position, 10 sweep, 11 reserved (= off)
//  cfg_pos      in   4   fixed position 1..15; 0 = no flip
//  in_valid     in   1   input word valid
//  in_ready     out  1   input word accepted when in_valid & in_ready
//  in_data      in   11  data word; bit k = data input k+1 (in1..in11)
//  out_valid    out  1   codeword valid
//  out_ready    in   1   downstream accepts when out_valid & out_ready
//  out_code     out  15  codeword; bit i = codeword position i+1
//  out_pos      out  4   position flipped in out_code; 0 = none
//  busy         out  1   state != IDLE
//  word_cnt     out  CNT_W  words accepted since reset (saturates at all-ones)
//  err_cnt      out  CNT_W  words emitted with out_pos != 0 (saturates)
// BEHAVIOUR
//  Reset: state = IDLE; out_valid = 0; out_code = 0; out_pos = 0; word_cnt = 0; err_cnt = 0;
//    sweep_pos = 1; mode_q = 00; pos_q = 0. Reset dominates every other input on the same edge.
//  FSM states:
//    IDLE  -start->  RUN: latch mode_q = cfg_mode, pos_q = cfg_pos; set sweep_pos = 1.
//    RUN   -stop->   DRAIN.
//    DRAIN -> IDLE once out_valid == 0, or once the held word is taken (out_ready) that cycle.
//  Start and stop in the same cycle while IDLE: start wins, stop ignored.
//  Input handshake:
//    in_ready = (state == RUN) & (~out_valid | out_ready). Low in IDLE and DRAIN.
//    A stop cycle still accepts a word if in_ready is high that cycle.
//  Latency: 1 cycle. An accepted word appears on out_code/out_pos the next cycle.
//    With out_ready held high, one word per cycle sustained.
//  Output register:
//    Holds out_code/out_pos stable while out_valid & ~out_ready.
//    out_valid clears on take without a new accept.
//  Encoding:
//    Parity at positions 1,2,4,8.
//    Data bits 1..11 at positions 3,5,6,7,9,10,11,12,13,14,15.
//    Parity p at position 2^j = XOR of data positions whose index has bit j set (even parity).
//  Position select at accept:
//    off/reserved: 0.
//    fixed: pos_q.
//    sweep: sweep_pos. After each accept sweep_pos increments 1..15, then wraps 15 -> 1 (never 0).
//    out_code = enc(in_data) ^ (pos ? 1<<(pos-1) : 0).
//  Counters:
//    word_cnt increments on every input accept.
//    err_cnt increments on the accept whose selected position is nonzero.
//    Both saturate; both clear only on reset.
//  Config changes while not IDLE are ignored until the next start.
// CONFIGURATION
//  HAMMING15_DOUBLE_ERR_EN defined:
//    when the selected position p != 0, also flip position (p mod 15)+1 (a double error).
//    out_pos reports p; err_cnt counts words, not flips.
//  HAMMING15_DOUBLE_ERR_EN undefined: single flip only; no second-position logic.
// STRUCTURE
//  Package hamming15_pkg: mode enum (MODE_OFF, MODE_FIXED, MODE_SWEEP), FSM state enum,
//    POS_NONE = 4'd0, POS_MAX = 4'd15, parity position constants.
//  Sub-module hamming15_enc: combinational 11 -> 15 encoder with a 4-bit flip position input.
//  Handshake, FSM, sweep counter and statistics live in the top.
// TESTING
//  1. Mode off; in_data 11'h000, then 11'h7FF -> out_code 15'h0000, then 15'h7FFF; out_pos 0; err_cnt 0.
//  2. Fixed, cfg_pos 3; in_data 11'h000 -> out_code 15'h0004, out_pos 3, err_cnt 1.
//  3. Sweep; 16 zero words -> out_code 15'h0001, 15'h0002, ..., 15'h4000, then 15'h0001 (wrap to pos 1).
//  4. out_ready low 5 cycles with a word held -> out_code stable, in_ready 0; release -> next word one cycle later.
//  5. stop while word held -> DRAIN, in_ready 0; take -> IDLE, busy 0; a start in DRAIN is ignored.
//  6. reset asserted mid-RUN with out_valid 1 -> next cycle: out_valid 0, counters 0, IDLE.
//     With HAMMING15_DOUBLE_ERR_EN: fixed pos 15 on zero data -> 15'h4001.

Source files
------------

// File: rtl/hamming15_pkg.sv
// -----------------------------------------------------------------------------
// hamming15_pkg
//   Shared types and constants for the Hamming(15,11) error-injection scheduler.
//   - mode_e   : injection mode as programmed through cfg_mode
//   - state_e  : scheduler FSM states
//   - position constants (POS_NONE / POS_MAX, parity positions 1,2,4,8)
//   - parity coverage masks over the 15-bit codeword (bit i = position i+1)
//   - small helpers for flip-mask generation and 1..15 wrap-around
// -----------------------------------------------------------------------------
package hamming15_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_FIXED = 2'b01,
        MODE_SWEEP = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [3:0] POS_NONE = 4'd0;
    localparam logic [3:0] POS_MIN  = 4'd1;
    localparam logic [3:0] POS_MAX  = 4'd15;

    // Parity bits sit at the power-of-two positions.
    localparam logic [3:0] PAR_POS_1 = 4'd1;
    localparam logic [3:0] PAR_POS_2 = 4'd2;
    localparam logic [3:0] PAR_POS_4 = 4'd4;
    localparam logic [3:0] PAR_POS_8 = 4'd8;

    // Positions whose index has bit j set (bit i of a mask = position i+1).
    // Parity bits are zero when these masks are applied, so including their
    // own position in the mask is harmless.
    localparam logic [14:0] PAR_MASK_1 = 15'h5555;
    localparam logic [14:0] PAR_MASK_2 = 15'h6666;
    localparam logic [14:0] PAR_MASK_4 = 15'h7878;
    localparam logic [14:0] PAR_MASK_8 = 15'h7F80;

    // One-hot flip mask for a position 1..15; position 0 flips nothing.
    function automatic logic [14:0] pos_mask(input logic [3:0] p);
        logic [14:0] m;
        if (p == POS_NONE) begin
            m = '0;
        end else begin
            m = 15'd1 << (p - 4'd1);
        end
        return m;
    endfunction

    // Advance a position through 1..15 and wrap back to 1 (never 0).
    function automatic logic [3:0] wrap_inc(input logic [3:0] p);
        logic [3:0] n;
        if (p == POS_MAX) begin
            n = POS_MIN;
        end else begin
            n = p + 4'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/hamming15_enc.sv
// -----------------------------------------------------------------------------
// hamming15_enc
//   Combinational Hamming(15,11) encoder with error injection.
//   Data bits 1..11 go to positions 3,5,6,7,9,10,11,12,13,14,15; even parity
//   at positions 1,2,4,8. The codeword bit at i_pos (1..15) is then inverted;
//   i_pos = 0 leaves the codeword clean.
//
//   Build option: HAMMING15_DOUBLE_ERR_EN
//     defined   -> for i_pos = p != 0, position (p mod 15)+1 is flipped as well
//     undefined -> single flip only
//
// Ports
//   i_data [10:0]  data word, bit k = data input k+1
//   i_pos  [3:0]   position to flip, 0 = none
//   o_code [14:0]  codeword, bit i = position i+1
// -----------------------------------------------------------------------------
module hamming15_enc
    import hamming15_pkg::*;
(
    input  logic [10:0] i_data,
    input  logic [3:0]  i_pos,
    output logic [14:0] o_code
);

    logic [14:0] w_data_pos;
    logic [14:0] w_clean;
    logic [14:0] w_flip;

    // Scatter data into the non-power-of-two positions, parity slots zero.
    assign w_data_pos = {i_data[10:4], 1'b0, i_data[3:1], 1'b0, i_data[0], 2'b00};

    always_comb begin
        w_clean                  = w_data_pos;
        w_clean[PAR_POS_1 - 4'd1] = ^(w_data_pos & PAR_MASK_1);
        w_clean[PAR_POS_2 - 4'd1] = ^(w_data_pos & PAR_MASK_2);
        w_clean[PAR_POS_4 - 4'd1] = ^(w_data_pos & PAR_MASK_4);
        w_clean[PAR_POS_8 - 4'd1] = ^(w_data_pos & PAR_MASK_8);
    end

`ifdef HAMMING15_DOUBLE_ERR_EN
    // Second flip sits one position above the first, wrapping 15 -> 1.
    always_comb begin
        w_flip = pos_mask(i_pos);
        if (i_pos != POS_NONE) begin
            w_flip = w_flip | pos_mask(wrap_inc(i_pos));
        end
    end
`else
    assign w_flip = pos_mask(i_pos);
`endif

    assign o_code = w_clean ^ w_flip;

endmodule

// File: rtl/hamming15_inject_sched.sv
// -----------------------------------------------------------------------------
// hamming15_inject_sched
//   Scheduler around the Hamming(15,11) encoder for the ECC test harness.
//   Accepts 11-bit words over valid/ready, picks a flip position per word
//   (off / fixed / sweep 1..15), and presents the corrupted codeword through a
//   registered valid/ready output stage (1-cycle latency, full throughput).
//   Also keeps saturating counts of accepted words and injected words.
//
//   Build option: HAMMING15_DOUBLE_ERR_EN (double-bit injection, see
//   hamming15_enc); out_pos and err_cnt are unaffected by it.
//
// Parameters
//   CNT_W        width of word_cnt / err_cnt
// Ports
//   clock        clock, all state on posedge
//   reset        synchronous active-high reset
//   start        pulse: latch cfg_*, IDLE -> RUN
//   stop         pulse: RUN -> DRAIN
//   cfg_mode[1:0] 00 off, 01 fixed, 10 sweep, 11 reserved (= off)
//   cfg_pos[3:0] fixed flip position, 0 = none
//   in_valid / in_ready / in_data[10:0]    input word handshake
//   out_valid / out_ready / out_code[14:0] / out_pos[3:0]  codeword handshake
//   busy         state != IDLE
//   word_cnt     accepted words (saturating)
//   err_cnt      accepted words with a nonzero flip position (saturating)
// -----------------------------------------------------------------------------
module hamming15_inject_sched
    import hamming15_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       cfg_mode,
    input  logic [3:0]       cfg_pos,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [10:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [14:0]      out_code,
    output logic [3:0]       out_pos,
    output logic             busy,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    state_e             r_state;
    mode_e              r_mode_q;
    logic [3:0]         r_pos_q;
    logic [3:0]         r_sweep_pos;
    logic               r_out_valid;
    logic [14:0]        r_out_code;
    logic [3:0]         r_out_pos;
    logic [CNT_W-1:0]   r_word_cnt;
    logic [CNT_W-1:0]   r_err_cnt;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_take;
    logic [3:0]         w_sel_pos;
    logic [14:0]        w_enc_code;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] n;
        if (&v) begin
            n = v;
        end else begin
            n = v + CNT_W'(1);
        end
        return n;
    endfunction

    // The output slot can take a new word when empty or being emptied now.
    assign w_in_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_take     = r_out_valid && out_ready;

    always_comb begin
        case (r_mode_q)
            MODE_FIXED: w_sel_pos = r_pos_q;
            MODE_SWEEP: w_sel_pos = r_sweep_pos;
            default:    w_sel_pos = POS_NONE;
        endcase
    end

    hamming15_enc u_enc (
        .i_data (in_data),
        .i_pos  (w_sel_pos),
        .o_code (w_enc_code)
    );

    // FSM and configuration latch. Configuration is captured only on the
    // IDLE start, so cfg_* may change freely while a run is in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mode_q    <= MODE_OFF;
            r_pos_q     <= POS_NONE;
            r_sweep_pos <= POS_MIN;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_RUN;
                        r_mode_q    <= mode_e'(cfg_mode);
                        r_pos_q     <= cfg_pos;
                        r_sweep_pos <= POS_MIN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Leave once the output slot is empty or emptied this cycle.
                    if (!r_out_valid || out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Accepts only happen in RUN, so this never races the IDLE reload.
            if (w_accept && (r_mode_q == MODE_SWEEP)) begin
                r_sweep_pos <= wrap_inc(r_sweep_pos);
            end
        end
    end

    // Output register stage: load on accept, hold under backpressure.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_code  <= '0;
            r_out_pos   <= POS_NONE;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_code  <= w_enc_code;
            r_out_pos   <= w_sel_pos;
        end else if (w_take) begin
            r_out_valid <= 1'b0;
        end
    end

    // Statistics, counted at accept time.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_word_cnt <= '0;
            r_err_cnt  <= '0;
        end else if (w_accept) begin
            r_word_cnt <= sat_inc(r_word_cnt);
            if (w_sel_pos != POS_NONE) begin
                r_err_cnt <= sat_inc(r_err_cnt);
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_code  = r_out_code;
    assign out_pos   = r_out_pos;
    assign busy      = (r_state != ST_IDLE);
    assign word_cnt  = r_word_cnt;
    assign err_cnt   = r_err_cnt;

endmodule
